// File: rtl/tqvp_cordic_pkg.sv
// Shared types and constants for the CORDIC sequencer: FSM states, gain constant
// and the saturating negate used by the quadrant fix-up.
package tqvp_cordic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REDUCE = 3'd1,
        ST_LOAD   = 3'd2,
        ST_STEP   = 3'd3,
        ST_FIXUP  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // CORDIC gain 0.6072529 in Q2.30; the engine starts x at this value.
    localparam logic [31:0] CORDIC_K = 32'h26DD_3B6A;

    // Two's complement negate; the most negative value clips to the most positive.
    function automatic logic [31:0] sat_neg(input logic [31:0] v);
        if (v == 32'h8000_0000)
            return 32'h7FFF_FFFF;
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/tqvp_cordic_quadrant_fix.sv
// Maps the first-quadrant engine result back into the quadrant chosen by the
// reducer: a rotation by q * 90 degrees of (x, y).
module tqvp_cordic_quadrant_fix
    import tqvp_cordic_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [1:0]  q,
    output logic [31:0] cos,
    output logic [31:0] sin
);

    always_comb begin
        cos = x;
        sin = y;
        case (q)
            2'd0: begin cos = x;          sin = y;          end
            2'd1: begin cos = sat_neg(y); sin = x;          end
            2'd2: begin cos = sat_neg(x); sin = sat_neg(y); end
            2'd3: begin cos = y;          sin = sat_neg(x); end
            default: begin cos = x;       sin = y;          end
        endcase
    end

endmodule

// File: rtl/tqvp_cordic_sequencer.sv
// Sequences one CORDIC command: reducer launch, engine load, ITERS micro-rotations,
// quadrant fix-up and registered results with a sticky completion interrupt.
//
//   state  | meaning
//   IDLE   | no command since reset, ready for one
//   REDUCE | reducer launched, waiting for its result or the timeout
//   LOAD   | engine loaded with x=K, y=0, z=eng_angle
//   STEP   | one micro-rotation per cycle, eng_iter = 0..ITERS-1
//   FIXUP  | engine final, quadrant-corrected results registered
//   DONE   | results valid, ready for the next command
module tqvp_cordic_sequencer
    import tqvp_cordic_pkg::*;
#(
    parameter int ITERS   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_angle,
    output logic        cmd_ready,
    input  logic        irq_clear,
    output logic        red_in_valid,
    output logic [31:0] red_data,
    input  logic        red_out_valid,
    input  logic [4:0]  red_q,
    input  logic [63:0] red_f,
    output logic        eng_load,
    output logic [31:0] eng_angle,
    output logic        eng_step,
    output logic [4:0]  eng_iter,
    input  logic [31:0] eng_x,
    input  logic [31:0] eng_y,
    output logic [31:0] res_cos,
    output logic [31:0] res_sin,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    output logic        overrun,
    output logic        irq
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [TW-1:0]   tmo_cnt;
    logic [1:0]      quad;
    logic [31:0]     fix_cos;
    logic [31:0]     fix_sin;
    logic            unused_ok;

    assign unused_ok = ^{red_q[4:2], red_f[31:0]};

    tqvp_cordic_quadrant_fix u_fix (
        .x   (eng_x),
        .y   (eng_y),
        .q   (quad),
        .cos (fix_cos),
        .sin (fix_sin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            tmo_cnt      <= '0;
            quad         <= 2'd0;
            red_data     <= 32'd0;
            eng_angle    <= 32'd0;
            res_cos      <= 32'd0;
            res_sin      <= 32'd0;
            red_in_valid <= 1'b0;
            eng_load     <= 1'b0;
            eng_step     <= 1'b0;
            eng_iter     <= 5'd0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_timeout  <= 1'b0;
            overrun      <= 1'b0;
            irq          <= 1'b0;
        end else begin
            red_in_valid <= 1'b0;
            eng_load     <= 1'b0;

            // Clears first so that a set later in this block wins the collision.
            if (irq_clear) begin
                irq         <= 1'b0;
                err_timeout <= 1'b0;
                overrun     <= 1'b0;
            end
            if (cmd_valid && !cmd_ready)
                overrun <= 1'b1;

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (cmd_valid) begin
                        state        <= ST_REDUCE;
                        red_data     <= cmd_angle;
                        red_in_valid <= 1'b1;
                        tmo_cnt      <= TW'(TIMEOUT - 1);
                        cmd_ready    <= 1'b0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                    end
                end
                ST_REDUCE: begin
                    if (red_out_valid) begin
                        state     <= ST_LOAD;
                        eng_angle <= red_f[63:32];
                        quad      <= red_q[1:0];
                        eng_load  <= 1'b1;
                    end else if (tmo_cnt == '0) begin
                        state       <= ST_DONE;
                        err_timeout <= 1'b1;
                        irq         <= 1'b1;
                        cmd_ready   <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                ST_LOAD: begin
                    state    <= ST_STEP;
                    eng_step <= 1'b1;
                    eng_iter <= 5'd0;
                end
                ST_STEP: begin
                    if (eng_iter == 5'(ITERS - 1)) begin
                        state    <= ST_FIXUP;
                        eng_step <= 1'b0;
                        eng_iter <= 5'd0;
                    end else begin
                        eng_iter <= eng_iter + 5'd1;
                    end
                end
                ST_FIXUP: begin
                    state     <= ST_DONE;
                    res_cos   <= fix_cos;
                    res_sin   <= fix_sin;
                    irq       <= 1'b1;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    eng_step  <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tqvp_cordic_sequencer.sv
// Directed bench for the CORDIC sequencer with behavioural reducer and engine models.
module tb_tqvp_cordic_sequencer;
    import tqvp_cordic_pkg::*;

    localparam int ITERS   = 16;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_angle = 32'd0;
    logic        irq_clear = 1'b0;
    logic        red_out_valid = 1'b0;
    logic [4:0]  red_q = 5'd0;
    logic [63:0] red_f = 64'd0;
    logic [31:0] eng_x = 32'd0;
    logic [31:0] eng_y = 32'd0;
    logic        cmd_ready, red_in_valid, eng_load, eng_step;
    logic        busy, done, err_timeout, overrun, irq;
    logic [31:0] red_data, eng_angle, res_cos, res_sin;
    logic [4:0]  eng_iter;

    tqvp_cordic_sequencer #(.ITERS(ITERS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_angle(cmd_angle),
        .cmd_ready(cmd_ready), .irq_clear(irq_clear), .red_in_valid(red_in_valid),
        .red_data(red_data), .red_out_valid(red_out_valid), .red_q(red_q),
        .red_f(red_f), .eng_load(eng_load), .eng_angle(eng_angle),
        .eng_step(eng_step), .eng_iter(eng_iter), .eng_x(eng_x), .eng_y(eng_y),
        .res_cos(res_cos), .res_sin(res_sin), .busy(busy), .done(done),
        .err_timeout(err_timeout), .overrun(overrun), .irq(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reducer model: answers red_lat cycles after the launch pulse unless muted.
    int          red_lat  = 3;
    logic        red_mute = 1'b0;
    logic [4:0]  m_q = 5'd0;
    logic [63:0] m_f = 64'd0;
    int          red_cnt = 0;
    always @(posedge clk) begin
        red_out_valid <= 1'b0;
        if (red_in_valid && !red_mute) begin
            red_cnt <= red_lat;
        end else if (red_cnt != 0) begin
            red_cnt <= red_cnt - 1;
            if (red_cnt == 1) begin
                red_out_valid <= 1'b1;
                red_q         <= m_q;
                red_f         <= m_f;
            end
        end
    end

    // Engine model: starts at (K, 0), presents programmed final values after ITERS steps.
    logic [31:0] m_x = 32'd0;
    logic [31:0] m_y = 32'd0;
    int          nsteps = 0;
    always @(posedge clk) begin
        if (eng_load) begin
            eng_x  <= CORDIC_K;
            eng_y  <= 32'd0;
            nsteps <= 0;
        end else if (eng_step) begin
            nsteps <= nsteps + 1;
            if (nsteps == ITERS - 1) begin
                eng_x <= m_x;
                eng_y <= m_y;
            end
        end
    end

    // Strobe monitor, cumulative counts and cycle stamps.
    int n_rin = 0, n_load = 0, n_step = 0, iter_err = 0, exp_iter = 0;
    int t_rin = 0, t_b = 0;
    always @(negedge clk) begin
        if (red_in_valid) begin n_rin++; t_rin = cyc; end
        if (red_out_valid) t_b = cyc;
        if (eng_load) begin n_load++; exp_iter = 0; end
        if (eng_step) begin
            n_step++;
            if (int'(eng_iter) != exp_iter) iter_err++;
            exp_iter++;
        end
    end

    typedef struct {
        logic [31:0] angle;
        logic [4:0]  q;
        logic [63:0] f;
        logic [31:0] x;
        logic [31:0] y;
        int          lat;
        logic [31:0] exp_cos;
        logic [31:0] exp_sin;
    } vec_t;

    vec_t vecs[8];
    int   t_acc, t_done;
    int   b_rin, b_load, b_step, b_ierr;
    bit   ok;

    task automatic start_cmd(input logic [31:0] angle);
        @(negedge clk); irq_clear = 1'b1;
        @(negedge clk); irq_clear = 1'b0;
        chk("irq_cleared_before_cmd", {31'd0, irq}, 32'd0);
        b_rin = n_rin; b_load = n_load; b_step = n_step; b_ierr = iter_err;
        cmd_valid = 1'b1;
        cmd_angle = angle;
        t_acc = cyc;
        @(negedge clk); cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin t_done = cyc; ok = 1'b1; break; end
        end
        chk("done_wait", {31'd0, ok}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        m_q = v.q; m_f = v.f; m_x = v.x; m_y = v.y; red_lat = v.lat;
        start_cmd(v.angle);
        wait_done();
        chk({tag, "_cos"}, res_cos, v.exp_cos);
        chk({tag, "_sin"}, res_sin, v.exp_sin);
        chk({tag, "_irq"}, {31'd0, irq}, 32'd1);
        chk({tag, "_rin_latency"}, 32'(t_rin - t_acc), 32'd1);
        chk({tag, "_done_latency"}, 32'(t_done - t_b), 32'(ITERS + 3));
        chk({tag, "_n_rin"}, 32'(n_rin - b_rin), 32'd1);
        chk({tag, "_n_load"}, 32'(n_load - b_load), 32'd1);
        chk({tag, "_n_step"}, 32'(n_step - b_step), 32'(ITERS));
        chk({tag, "_iter_order"}, 32'(iter_err - b_ierr), 32'd0);
        chk({tag, "_eng_angle"}, eng_angle, v.f[63:32]);
        chk({tag, "_red_data"}, red_data, v.angle);
        chk({tag, "_flags"}, {29'd0, err_timeout, overrun, cmd_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h0000_0000, 5'd0, 64'h0000_0000_0000_0000, 32'h4000_0000, 32'h0000_0000, 3, 32'h4000_0000, 32'h0000_0000};
        vecs[1] = '{32'h1111_0000, 5'd1, 64'h1234_5678_0000_0001, 32'h4000_0000, 32'h0000_0000, 3, 32'h0000_0000, 32'h4000_0000};
        vecs[2] = '{32'h2222_0000, 5'd2, 64'h2345_6789_0000_0002, 32'h4000_0000, 32'h0000_0000, 1, 32'hC000_0000, 32'h0000_0000};
        vecs[3] = '{32'h3333_0000, 5'd3, 64'h3456_789A_0000_0003, 32'h4000_0000, 32'h0000_0000, 5, 32'h0000_0000, 32'hC000_0000};
        vecs[4] = '{32'h4444_0000, 5'd2, 64'h0ABC_DEF0_0000_0004, 32'h8000_0000, 32'h1234_5678, 2, 32'h7FFF_FFFF, 32'hEDCB_A988};
        vecs[5] = '{32'h5555_0000, 5'd1, 64'h1000_0001_0000_0005, 32'h1000_0000, 32'h8000_0000, 3, 32'h7FFF_FFFF, 32'h1000_0000};
        vecs[6] = '{32'h6666_0000, 5'd3, 64'h2000_0002_0000_0006, 32'h3000_0000, 32'hF000_0000, 4, 32'hF000_0000, 32'hD000_0000};
        vecs[7] = '{32'h7777_0000, 5'd5, 64'h3000_0003_0000_0007, 32'h2000_0000, 32'h1000_0000, 3, 32'hF000_0000, 32'h2000_0000};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ctrl", {27'd0, cmd_ready, busy, done, irq, err_timeout}, 32'h10);
        chk("reset_strobes", {29'd0, red_in_valid, eng_load, eng_step}, 32'd0);
        chk("reset_res_cos", res_cos, 32'd0);
        chk("reset_res_sin", res_sin, 32'd0);
        chk("reset_overrun", {31'd0, overrun}, 32'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reducer never answers: exit through the timeout with results held.
        red_mute = 1'b1;
        start_cmd(32'hAAAA_5555);
        wait_done();
        chk("tmo_latency", 32'(t_done - t_acc), 32'(TIMEOUT + 1));
        chk("tmo_err", {31'd0, err_timeout}, 32'd1);
        chk("tmo_irq", {31'd0, irq}, 32'd1);
        chk("tmo_cos_hold", res_cos, 32'hF000_0000);
        chk("tmo_sin_hold", res_sin, 32'h2000_0000);
        chk("tmo_no_load", 32'(n_load - b_load), 32'd0);
        red_mute = 1'b0;
        @(negedge clk); irq_clear = 1'b1;
        @(negedge clk); irq_clear = 1'b0;
        chk("tmo_cleared", {30'd0, err_timeout, irq}, 32'd0);

        // Overrun: second command during STEP must be dropped.
        m_q = 5'd0; m_f = 64'h5555_0000_0000_0000; m_x = 32'h1111_1111; m_y = 32'h2222_2222; red_lat = 3;
        start_cmd(32'hBEEF_0001);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (eng_step) begin ok = 1'b1; break; end
        end
        chk("ovr_reach_step", {31'd0, ok}, 32'd1);
        cmd_valid = 1'b1; cmd_angle = 32'hDEAD_0002;
        @(negedge clk); cmd_valid = 1'b0;
        wait_done();
        chk("ovr_flag", {31'd0, overrun}, 32'd1);
        chk("ovr_n_rin", 32'(n_rin - b_rin), 32'd1);
        chk("ovr_cos", res_cos, 32'h1111_1111);
        chk("ovr_sin", res_sin, 32'h2222_2222);
        chk("ovr_red_data", red_data, 32'hBEEF_0001);
        chk("ovr_n_step", 32'(n_step - b_step), 32'(ITERS));
        repeat (4) @(negedge clk);
        chk("ovr_no_restart", {31'd0, done}, 32'd1);

        // irq_clear coinciding with DONE entry: set wins.
        m_q = 5'd0; m_f = 64'h6666_0000_0000_0000; m_x = 32'h0ABC_DEF0; m_y = 32'h0123_4567;
        start_cmd(32'hC0DE_0003);
        chk("col_ovr_cleared", {31'd0, overrun}, 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy && !eng_step && (n_step - b_step) == ITERS) begin ok = 1'b1; break; end
        end
        chk("col_reach_fixup", {31'd0, ok}, 32'd1);
        irq_clear = 1'b1;
        @(negedge clk); irq_clear = 1'b0;
        chk("col_done", {31'd0, done}, 32'd1);
        chk("col_irq_set_wins", {31'd0, irq}, 32'd1);
        chk("col_cos", res_cos, 32'h0ABC_DEF0);
        @(negedge clk); irq_clear = 1'b1;
        @(negedge clk); irq_clear = 1'b0;
        chk("col_irq_then_clear", {31'd0, irq}, 32'd0);

        // Reset in the middle of STEP.
        m_q = 5'd1; m_f = 64'h7777_0000_0000_0000; m_x = 32'h0100_0000; m_y = 32'h0200_0000;
        start_cmd(32'hFACE_0004);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ((n_step - b_step) >= 5) begin ok = 1'b1; break; end
        end
        chk("rst_reach_step", {31'd0, ok}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ctrl", {27'd0, cmd_ready, busy, done, irq, err_timeout}, 32'h10);
        chk("rst_mid_strobes", {29'd0, red_in_valid, eng_load, eng_step}, 32'd0);
        chk("rst_mid_res", res_cos | res_sin, 32'd0);
        chk("rst_mid_data", red_data | eng_angle, 32'd0);
        chk("rst_mid_iter_ovr", {26'd0, eng_iter, overrun}, 32'd0);
        rst = 1'b0;
        b_step = n_step;
        repeat (3) @(negedge clk);
        chk("rst_no_more_steps", 32'(n_step - b_step), 32'd0);
        chk("rst_idle", {30'd0, busy, cmd_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
